// File: rtl/fec23_dec.sv
// Rate-2/3 shortened-Hamming (15,10) payload decoder with single-error correction,
// serial info-bit emission and saturating error statistics; bypass forwards raw bits.
module fec23_dec #(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                dec_py_st_p,
    input  logic                dec_py_period,
    input  logic                fec23_en,
    input  logic                rxbit,
    input  logic                rxbit_valid_p,
    output logic                pydecdatout,
    output logic                py_datvalid_p,
    output logic                blk_corr_p,
    output logic                blk_uncorr_p,
    output logic [ERRCNT_W-1:0] corr_cnt,
    output logic [ERRCNT_W-1:0] uncorr_cnt
);

    typedef enum logic [0:0] {
        EMIT_IDLE = 1'b0,
        EMIT      = 1'b1
    } emit_st_t;

    localparam logic [ERRCNT_W-1:0] CNT_MAX = {ERRCNT_W{1'b1}};

    // One Horner step of r(D) mod g(D), g = D^5+D^4+D^2+1, bits arriving high order first.
    function automatic logic [4:0] syn_step(input logic [4:0] s, input logic b);
        logic [4:0] v;
        v = {s[3:0], b};
        if (s[4]) begin
            v = v ^ 5'b10101;
        end else begin
            v = v ^ 5'b00000;
        end
        return v;
    endfunction

    // Maps a syndrome to {hit, bit index j}; zero and unlisted syndromes miss.
    function automatic logic [4:0] syn_lookup(input logic [4:0] s);
        logic [4:0] r;
        case (s)
            5'b11010: r = {1'b1, 4'd0};
            5'b01101: r = {1'b1, 4'd1};
            5'b11100: r = {1'b1, 4'd2};
            5'b01110: r = {1'b1, 4'd3};
            5'b00111: r = {1'b1, 4'd4};
            5'b11001: r = {1'b1, 4'd5};
            5'b10110: r = {1'b1, 4'd6};
            5'b01011: r = {1'b1, 4'd7};
            5'b11111: r = {1'b1, 4'd8};
            5'b10101: r = {1'b1, 4'd9};
            5'b10000: r = {1'b1, 4'd10};
            5'b01000: r = {1'b1, 4'd11};
            5'b00100: r = {1'b1, 4'd12};
            5'b00010: r = {1'b1, 4'd13};
            5'b00001: r = {1'b1, 4'd14};
            default:  r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    logic [3:0]          r_j;
    logic [4:0]          r_syn;
    logic [9:0]          r_coll;
    logic                r_load;
    logic [4:0]          r_blk_syn;
    logic [9:0]          r_blk_info;
    emit_st_t            r_state;
    emit_st_t            w_state_nxt;
    logic [9:0]          r_emit_buf;
    logic [3:0]          r_emit_idx;
    logic                r_dout;
    logic                r_dv;
    logic                r_corr_p;
    logic                r_uncorr_p;
    logic [ERRCNT_W-1:0] r_corr_cnt;
    logic [ERRCNT_W-1:0] r_uncorr_cnt;

    logic                w_accept;
    logic                w_decode;
    logic                w_bypass;
    logic [4:0]          w_lookup;
    logic                w_hit;
    logic [3:0]          w_pos;
    logic [9:0]          w_fix_mask;
    logic [9:0]          w_info_fix;
    logic                w_emit_go;

    assign w_accept   = rxbit_valid_p & dec_py_period & ~dec_py_st_p;
    // Mode is only looked at on a block boundary; mid-block the block stays in decode.
    assign w_decode   = (r_j != 4'd0) | fec23_en;
    assign w_bypass   = w_accept & ~w_decode;
    assign w_lookup   = syn_lookup(r_blk_syn);
    assign w_hit      = w_lookup[4];
    assign w_pos      = w_lookup[3:0];
    assign w_info_fix = r_blk_info ^ w_fix_mask;

    // Correction mask: only a hit on an information position flips data.
    always_comb begin
        w_fix_mask = 10'd0;
        if (w_hit && (w_pos <= 4'd9)) begin
            w_fix_mask = 10'd1 << w_pos;
        end else begin
            w_fix_mask = 10'd0;
        end
    end

    // Collect: bit index, info shift register, syndrome LFSR and hand-off buffer.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_j        <= 4'd0;
            r_syn      <= 5'd0;
            r_coll     <= 10'd0;
            r_load     <= 1'b0;
            r_blk_syn  <= 5'd0;
            r_blk_info <= 10'd0;
        end else if (dec_py_st_p) begin
            r_j        <= 4'd0;
            r_syn      <= 5'd0;
            r_coll     <= 10'd0;
            r_load     <= 1'b0;
            r_blk_syn  <= 5'd0;
            r_blk_info <= 10'd0;
        end else if (w_accept && w_decode) begin
            if (r_j < 4'd10) begin
                r_coll <= {rxbit, r_coll[9:1]};
            end else begin
                r_coll <= r_coll;
            end
            if (r_j == 4'd14) begin
                r_j        <= 4'd0;
                r_syn      <= 5'd0;
                r_blk_syn  <= syn_step(r_syn, rxbit);
                r_blk_info <= r_coll;
                r_load     <= 1'b1;
            end else begin
                r_j    <= r_j + 4'd1;
                r_syn  <= syn_step(r_syn, rxbit);
                r_load <= 1'b0;
            end
        end else if (!dec_py_period && (r_j != 4'd0)) begin
            r_j    <= 4'd0;
            r_syn  <= 5'd0;
            r_load <= 1'b0;
        end else begin
            r_load <= 1'b0;
        end
    end

    // Emit FSM state register.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state <= EMIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Emit FSM next state; a load always (re)starts a burst.
    always_comb begin
        w_state_nxt = r_state;
        w_emit_go   = 1'b0;
        if (dec_py_st_p) begin
            w_state_nxt = EMIT_IDLE;
        end else if (r_load) begin
            w_state_nxt = EMIT;
        end else begin
            case (r_state)
                EMIT_IDLE: w_state_nxt = EMIT_IDLE;
                EMIT: begin
                    if (r_emit_idx == 4'd10) begin
                        w_state_nxt = EMIT_IDLE;
                    end else begin
                        w_state_nxt = EMIT;
                        w_emit_go   = 1'b1;
                    end
                end
                default:   w_state_nxt = EMIT_IDLE;
            endcase
        end
    end

    // Output bit stream; a bypass bit colliding with a decoded burst is dropped.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_emit_buf <= 10'd0;
            r_emit_idx <= 4'd0;
            r_dout     <= 1'b0;
            r_dv       <= 1'b0;
        end else if (dec_py_st_p) begin
            r_emit_buf <= 10'd0;
            r_emit_idx <= 4'd0;
            r_dout     <= 1'b0;
            r_dv       <= 1'b0;
        end else if (r_load) begin
            r_emit_buf <= w_info_fix;
            r_emit_idx <= 4'd1;
            r_dout     <= w_info_fix[0];
            r_dv       <= 1'b1;
        end else if (w_emit_go) begin
            r_emit_idx <= r_emit_idx + 4'd1;
            r_dout     <= r_emit_buf[r_emit_idx];
            r_dv       <= 1'b1;
        end else if (w_bypass) begin
            r_dout <= rxbit;
            r_dv   <= 1'b1;
        end else begin
            r_dv <= 1'b0;
        end
    end

    // Block flags and saturating statistics, aligned with the load cycle.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_corr_p     <= 1'b0;
            r_uncorr_p   <= 1'b0;
            r_corr_cnt   <= {ERRCNT_W{1'b0}};
            r_uncorr_cnt <= {ERRCNT_W{1'b0}};
        end else if (dec_py_st_p) begin
            r_corr_p     <= 1'b0;
            r_uncorr_p   <= 1'b0;
            r_corr_cnt   <= {ERRCNT_W{1'b0}};
            r_uncorr_cnt <= {ERRCNT_W{1'b0}};
        end else begin
            r_corr_p   <= r_load & w_hit;
            r_uncorr_p <= r_load & ~w_hit & (r_blk_syn != 5'd0);
            if (r_load && w_hit && (r_corr_cnt != CNT_MAX)) begin
                r_corr_cnt <= r_corr_cnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_corr_cnt <= r_corr_cnt;
            end
            if (r_load && !w_hit && (r_blk_syn != 5'd0) && (r_uncorr_cnt != CNT_MAX)) begin
                r_uncorr_cnt <= r_uncorr_cnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_uncorr_cnt <= r_uncorr_cnt;
            end
        end
    end

    assign pydecdatout   = r_dout;
    assign py_datvalid_p = r_dv;
    assign blk_corr_p    = r_corr_p;
    assign blk_uncorr_p  = r_uncorr_p;
    assign corr_cnt      = r_corr_cnt;
    assign uncorr_cnt    = r_uncorr_cnt;

endmodule

// File: tb/tb_fec23_dec.sv
// Directed self-checking bench for fec23_dec: decode, correction, throughput,
// abort, partial-block discard, bypass and asynchronous reset.
module tb_fec23_dec;

    logic       clk_6M = 1'b0;
    logic       rstz = 1'b0;
    logic       dec_py_st_p = 1'b0;
    logic       dec_py_period = 1'b0;
    logic       fec23_en = 1'b0;
    logic       rxbit = 1'b0;
    logic       rxbit_valid_p = 1'b0;
    logic       pydecdatout;
    logic       py_datvalid_p;
    logic       blk_corr_p;
    logic       blk_uncorr_p;
    logic [7:0] corr_cnt;
    logic [7:0] uncorr_cnt;

    fec23_dec #(.ERRCNT_W(8)) dut (
        .clk_6M        (clk_6M),
        .rstz          (rstz),
        .dec_py_st_p   (dec_py_st_p),
        .dec_py_period (dec_py_period),
        .fec23_en      (fec23_en),
        .rxbit         (rxbit),
        .rxbit_valid_p (rxbit_valid_p),
        .pydecdatout   (pydecdatout),
        .py_datvalid_p (py_datvalid_p),
        .blk_corr_p    (blk_corr_p),
        .blk_uncorr_p  (blk_uncorr_p),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    always #5 clk_6M = ~clk_6M;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_corr = 0;
    int   n_uncorr = 0;
    int   s_last = 0;
    logic q_bits[$];
    int   q_cyc[$];

    localparam logic [0:14] CLEAN = 15'b100000000011010;

    always @(posedge clk_6M) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk_6M) begin
        if (py_datvalid_p) begin
            q_bits.push_back(pydecdatout);
            q_cyc.push_back(cyc);
        end
        if (blk_corr_p) n_corr <= n_corr + 1;
        if (blk_uncorr_p) n_uncorr <= n_uncorr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk_6M);
        rxbit         = b;
        rxbit_valid_p = 1'b1;
        s_last        = cyc;
        if (gap > 1) begin
            @(negedge clk_6M);
            rxbit_valid_p = 1'b0;
            repeat (gap - 2) @(negedge clk_6M);
        end
    endtask

    task automatic send_block(input logic [0:14] w, input int gap);
        for (int j = 0; j < 15; j++) send_bit(w[j], gap);
    endtask

    task automatic idle(input int n);
        @(negedge clk_6M);
        rxbit_valid_p = 1'b0;
        repeat (n - 1) @(negedge clk_6M);
    endtask

    task automatic py_start();
        @(negedge clk_6M);
        dec_py_st_p = 1'b1;
        @(negedge clk_6M);
        dec_py_st_p = 1'b0;
    endtask

    task automatic check_blk(input string tag, input int base, input logic [9:0] exp_v, input int strobe);
        logic [9:0] got;
        got = 10'd0;
        chk({tag, "_len"}, q_bits.size() - base, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < q_bits.size()) got[i] = q_bits[base + i];
        end
        chk({tag, "_data"}, {22'd0, got}, {22'd0, exp_v});
        if (q_bits.size() >= base + 10) begin
            chk({tag, "_lat"}, q_cyc[base], strobe + 2);
            chk({tag, "_burst"}, q_cyc[base + 9] - q_cyc[base], 32'd9);
        end
    endtask

    initial begin
        logic [0:14] w;
        int          base;
        int          c0;
        int          u0;
        int          ones;
        logic        b;
        logic        exp_bits[$];
        int          exp_cyc[$];

        repeat (3) @(negedge clk_6M);
        chk("rst_dv", py_datvalid_p, 0);
        chk("rst_dout", pydecdatout, 0);
        chk("rst_corr_p", blk_corr_p, 0);
        chk("rst_uncorr_p", blk_uncorr_p, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        rstz = 1'b1;
        dec_py_period = 1'b1;
        fec23_en = 1'b1;
        py_start();

        // clean block
        base = q_bits.size(); c0 = n_corr; u0 = n_uncorr;
        send_block(CLEAN, 6); idle(12);
        check_blk("clean", base, 10'b0000000001, s_last);
        chk("clean_flags", (n_corr - c0) + (n_uncorr - u0), 0);
        chk("clean_cnt", {corr_cnt, uncorr_cnt}, 16'h0000);

        // single info-bit error
        w = CLEAN; w[3] = ~w[3];
        base = q_bits.size(); c0 = n_corr;
        send_block(w, 6); idle(12);
        check_blk("err_j3", base, 10'b0000000001, s_last);
        chk("err_j3_pulse", n_corr - c0, 1);
        chk("err_j3_cnt", corr_cnt, 1);

        // single parity-bit error
        w = CLEAN; w[12] = ~w[12];
        base = q_bits.size(); c0 = n_corr;
        send_block(w, 6); idle(12);
        check_blk("err_j12", base, 10'b0000000001, s_last);
        chk("err_j12_pulse", n_corr - c0, 1);
        chk("err_j12_cnt", corr_cnt, 2);

        // double error: uncorrectable, data passes as received
        w = CLEAN; w[0] = ~w[0]; w[1] = ~w[1];
        base = q_bits.size(); c0 = n_corr; u0 = n_uncorr;
        send_block(w, 6); idle(12);
        check_blk("dbl", base, 10'b0000000010, s_last);
        chk("dbl_uncorr_pulse", n_uncorr - u0, 1);
        chk("dbl_corr_pulse", n_corr - c0, 0);
        chk("dbl_cnts", {corr_cnt, uncorr_cnt}, {8'd2, 8'd1});

        py_start();
        chk("stp_clear", {corr_cnt, uncorr_cnt}, 16'h0000);

        // FHS length payload at nominal and at full strobe rate
        for (int g = 0; g < 2; g++) begin
            base = q_bits.size(); c0 = n_corr; u0 = n_uncorr;
            for (int k = 0; k < 16; k++) send_block(15'd0, (g == 0) ? 6 : 1);
            idle(16);
            ones = 0;
            for (int i = base; i < q_bits.size(); i++) ones += int'(q_bits[i]);
            chk((g == 0) ? "fhs6_len" : "fhs1_len", q_bits.size() - base, 160);
            chk((g == 0) ? "fhs6_ones" : "fhs1_ones", ones, 0);
            chk((g == 0) ? "fhs6_flags" : "fhs1_flags", (n_corr - c0) + (n_uncorr - u0), 0);
        end

        // abort during the 5th emitted bit
        base = q_bits.size();
        send_block(CLEAN, 6);
        py_start();
        repeat (15) @(negedge clk_6M);
        chk("abort_len", q_bits.size() - base, 5);
        chk("abort_cnt", {corr_cnt, uncorr_cnt}, 16'h0000);

        // partial block dropped when the payload period ends
        base = q_bits.size(); c0 = n_corr; u0 = n_uncorr;
        w = CLEAN;
        for (int j = 0; j < 7; j++) send_bit(w[j], 6);
        @(negedge clk_6M);
        dec_py_period = 1'b0;
        repeat (20) @(negedge clk_6M);
        chk("partial_len", q_bits.size() - base, 0);
        chk("partial_flags", (n_corr - c0) + (n_uncorr - u0), 0);
        dec_py_period = 1'b1;
        base = q_bits.size();
        send_block(CLEAN, 6); idle(12);
        check_blk("post_partial", base, 10'b0000000001, s_last);

        // bypass
        @(negedge clk_6M);
        fec23_en = 1'b0;
        base = q_bits.size(); c0 = n_corr; u0 = n_uncorr;
        for (int i = 0; i < 20; i++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b, 6);
            exp_bits.push_back(b);
            exp_cyc.push_back(s_last + 1);
        end
        idle(4);
        chk("byp_len", q_bits.size() - base, 20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < q_bits.size()) begin
                chk("byp_bit", q_bits[base + i], exp_bits[i]);
                chk("byp_lat", q_cyc[base + i], exp_cyc[i]);
            end
        end
        chk("byp_flags", (n_corr - c0) + (n_uncorr - u0), 0);
        chk("byp_cnt", {corr_cnt, uncorr_cnt}, 16'h0000);

        // async reset mid-emission
        fec23_en = 1'b1;
        w = CLEAN; w[5] = ~w[5];
        send_block(w, 6);
        chk("pre_rst_dv", py_datvalid_p, 1);
        chk("pre_rst_cnt", corr_cnt, 1);
        rstz = 1'b0;
        #1;
        chk("arst_dv", py_datvalid_p, 0);
        chk("arst_dout", pydecdatout, 0);
        chk("arst_flags", {blk_corr_p, blk_uncorr_p}, 0);
        chk("arst_cnt", {corr_cnt, uncorr_cnt}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
